// File: rtl/seg7_scan_receiver.sv
// rtl/seg7_scan_receiver.sv - seven-segment scan bus receiver: glitch filter, segment decode, frame assembly
module seg7_scan_receiver #(
  parameter int DIGITS = 4,
  parameter int STABLE = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DIGITS-1:0]     sel,
  input  logic [6:0]            segmentos,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank,
  output logic [DIGITS-1:0]     erro,
  output logic                  quadro_valido,
  output logic                  sel_erro
);

  localparam int CW = $clog2(STABLE + 1);
  localparam int SW = DIGITS + 7;

  // s1 is the registered bus sample, s2 the sample before it
  logic [SW-1:0]        s1;
  logic [SW-1:0]        s2;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_next;
  logic                 same;
  logic                 accept;

  logic [DIGITS-1:0]    acc_sel_n;
  logic [6:0]           acc_seg;
  logic                 sel_one;
  logic                 sel_multi;

  logic [3:0]           dec_code;
  logic                 dec_blank;
  logic                 dec_erro;

  logic [4*DIGITS-1:0]  work_code;
  logic [DIGITS-1:0]    work_blank;
  logic [DIGITS-1:0]    work_erro;
  logic [DIGITS-1:0]    seen;
  logic [DIGITS-1:0]    seen_next;
  logic                 write_digit;

  // Stability counter and the single accept event at the moment it reaches STABLE
  always_comb begin
    same     = (s1 == s2);
    cnt_next = CW'(1);
    if (same) begin
      cnt_next = (cnt == CW'(STABLE)) ? cnt : cnt + CW'(1);
    end
    accept    = same && (cnt == CW'(STABLE - 1));
    acc_sel_n = ~s1[SW-1:7];
    acc_seg   = s1[6:0];
    sel_one   = $onehot(acc_sel_n);
    sel_multi = (acc_sel_n != '0) && !sel_one;
    write_digit = accept && sel_one;
  end

  // Segment pattern back to BCD; dark digit is F, anything unknown is E
  always_comb begin
    dec_code  = 4'hE;
    dec_blank = 1'b0;
    dec_erro  = 1'b0;
    case (acc_seg)
      7'b0000001: dec_code = 4'd0;
      7'b1001111: dec_code = 4'd1;
      7'b0010010: dec_code = 4'd2;
      7'b0000110: dec_code = 4'd3;
      7'b1001100: dec_code = 4'd4;
      7'b0100100: dec_code = 4'd5;
      7'b0100000: dec_code = 4'd6;
      7'b0001111: dec_code = 4'd7;
      7'b0000000: dec_code = 4'd8;
      7'b0000100: dec_code = 4'd9;
      7'b1111111: begin
        dec_code  = 4'hF;
        dec_blank = 1'b1;
      end
      default: begin
        dec_code = 4'hE;
        dec_erro = 1'b1;
      end
    endcase
  end

  // Seen mask: cleared when a full frame is published, then any new accept lands on top
  always_comb begin
    seen_next = (&seen) ? '0 : seen;
    if (write_digit) begin
      seen_next = seen_next | acc_sel_n;
    end
  end

  // Sampling, filtering, per-digit work registers and frame publication
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1            <= '0;
      s2            <= '0;
      cnt           <= '0;
      work_code     <= '0;
      work_blank    <= '0;
      work_erro     <= '0;
      seen          <= '0;
      bcd_out       <= '1;
      blank         <= '1;
      erro          <= '0;
      quadro_valido <= 1'b0;
      sel_erro      <= 1'b0;
    end else begin
      s1            <= {sel, segmentos};
      s2            <= s1;
      cnt           <= cnt_next;
      seen          <= seen_next;
      quadro_valido <= 1'b0;
      sel_erro      <= accept && sel_multi;
      if (&seen) begin
        bcd_out       <= work_code;
        blank         <= work_blank;
        erro          <= work_erro;
        quadro_valido <= 1'b1;
      end
      for (int i = 0; i < DIGITS; i++) begin
        if (write_digit && acc_sel_n[i]) begin
          work_code[4*i +: 4] <= dec_code;
          work_blank[i]       <= dec_blank;
          work_erro[i]        <= dec_erro;
        end
      end
    end
  end

endmodule
